// File: rtl/dm_store_buffer.sv
// MEM-stage store buffer: encodes sb/sh/sw into byte enables and lane-replicated data,
// queues them in a small FIFO and drains them to data memory over a req/ack handshake.
module dm_store_buffer #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [1:0]    st_type,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    output logic          st_ready,
    output logic          st_misalign,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_conflict,
    output logic          dm_req,
    output logic [AW-1:0] dm_addr,
    output logic [3:0]    dm_be,
    output logic [31:0]   dm_wdata,
    input  logic          dm_ack,
    output logic          empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-3:0]    addr_q [DEPTH];
    logic [AW-3:0]    addr_d [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [3:0]       be_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic        st_act_s, push_s, pop_s;
    logic [3:0]  enc_be_s;
    logic [31:0] enc_data_s;
    logic        ld_addr_unused_s;

    assign ld_addr_unused_s = ^ld_addr[1:0];

    // Request decode: lane encoding, misalignment check and handshake qualifiers.
    always_comb begin
        st_act_s    = st_valid & (st_type != 2'b00);
        enc_be_s    = 4'b0000;
        enc_data_s  = 32'h0000_0000;
        st_misalign = 1'b0;
        case (st_type)
            2'b01: begin
                enc_be_s   = 4'b0001 << st_addr[1:0];
                enc_data_s = {4{st_data[7:0]}};
            end
            2'b10: begin
                enc_be_s    = st_addr[1] ? 4'b1100 : 4'b0011;
                enc_data_s  = {2{st_data[15:0]}};
                st_misalign = st_act_s & st_addr[0];
            end
            2'b11: begin
                enc_be_s    = 4'b1111;
                enc_data_s  = st_data;
                st_misalign = st_act_s & (st_addr[1:0] != 2'b00);
            end
            default: begin
                enc_be_s = 4'b0000;
            end
        endcase
        st_ready = (count_q < DEPTH_C);
        empty    = (count_q == {CW{1'b0}});
        dm_req   = ~empty;
        push_s   = st_act_s & ~st_misalign & st_ready;
        pop_s    = dm_req & dm_ack;
    end

    // Head entry drives the memory port directly; retired slots are cleared so idle outputs read zero.
    always_comb begin
        dm_addr  = {addr_q[rd_ptr_q], 2'b00};
        dm_be    = be_q[rd_ptr_q];
        dm_wdata = data_q[rd_ptr_q];
    end

    // Load hazard: any valid entry in the same word, head included even while being acked.
    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_conflict = ld_conflict | (valid_q[i] & (addr_q[i] == ld_addr[AW-1:2]));
        end
        ld_conflict = ld_conflict & ld_valid;
    end

    // FIFO next state: retire head on ack, append on accepted push.
    always_comb begin
        addr_d   = addr_q;
        be_d     = be_q;
        data_d   = data_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pop_s) begin
            valid_d[rd_ptr_q] = 1'b0;
            addr_d[rd_ptr_q]  = '0;
            be_d[rd_ptr_q]    = 4'b0000;
            data_d[rd_ptr_q]  = 32'h0000_0000;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = st_addr[AW-1:2];
            be_d[wr_ptr_q]    = enc_be_s;
            data_d[wr_ptr_q]  = enc_data_s;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        count_d = count_q + CW'(push_s) - CW'(pop_s);
    end

    // State registers with immediate reset that discards all pending entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                be_q[i]   <= 4'b0000;
                data_q[i] <= 32'h0000_0000;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            be_q     <= be_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer: expected entries are queued at push time
// and compared against the dm_* port while each entry sits at the head.
module tb_dm_store_buffer;
    localparam int AW = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          st_valid;
    logic [1:0]    st_type;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          st_misalign;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_conflict;
    logic          dm_req;
    logic [AW-1:0] dm_addr;
    logic [3:0]    dm_be;
    logic [31:0]   dm_wdata;
    logic          dm_ack;
    logic          empty;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } ent_t;

    ent_t sb_q[$];
    ent_t pend_ent;
    logic pend_acc;
    ent_t head_s;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_type(st_type), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready), .st_misalign(st_misalign),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .empty(empty)
    );

    always #5 clk = ~clk;

    assign head_s = '{addr: dm_addr, be: dm_be, data: dm_wdata};

    function automatic ent_t model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        e.addr = {a[31:2], 2'b00};
        e.be   = 4'b0000;
        e.data = d;
        case (t)
            2'b01: begin e.be[a[1:0]] = 1'b1; e.data = {d[7:0], d[7:0], d[7:0], d[7:0]}; end
            2'b10: begin e.be = (a[1] == 1'b1) ? 4'b1100 : 4'b0011; e.data = {d[15:0], d[15:0]}; end
            2'b11: e.be = 4'b1111;
            default: e.be = 4'b0000;
        endcase
        return e;
    endfunction

    task automatic set_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                             input logic acc);
        st_valid = 1'b1;
        st_type  = t;
        st_addr  = a;
        st_data  = d;
        pend_ent = model(t, a, d);
        pend_acc = acc;
    endtask

    // Advances one clock and updates the scoreboard with the expected pop/push.
    task automatic clock_cycle();
        logic do_pop;
        do_pop = dm_ack && (sb_q.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop) void'(sb_q.pop_front());
        if (pend_acc) sb_q.push_back(pend_ent);
        st_valid = 1'b0;
        st_type  = 2'b00;
        dm_ack   = 1'b0;
        pend_acc = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        st_valid = 1'b0; st_type = 2'b00; st_addr = '0; st_data = '0;
        ld_valid = 1'b1; ld_addr = '0; dm_ack = 1'b0; pend_acc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++; if (st_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_ready got %b want 1", st_ready); end
        vec_cnt++; if (dm_req !== 1'b0) begin err_cnt++; $display("FAIL rst_req got %b want 0", dm_req); end
        vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL rst_empty got %b want 1", empty); end
        vec_cnt++; if (head_s !== '0) begin err_cnt++; $display("FAIL rst_head got %h want 0", head_s); end
        vec_cnt++; if (ld_conflict !== 1'b0) begin err_cnt++; $display("FAIL rst_conflict got %b want 0", ld_conflict); end
        ld_valid = 1'b0;
        reset = 1'b0;
        #2;
    endtask

    task automatic test_sb();
        set_store(2'b01, 32'h0000_1003, 32'h0000_00A5, 1'b1);
        #1;
        vec_cnt++; if (st_misalign !== 1'b0) begin err_cnt++; $display("FAIL sb_misalign got %b want 0", st_misalign); end
        clock_cycle();
        vec_cnt++; if (dm_req !== 1'b1) begin err_cnt++; $display("FAIL sb_req got %b want 1", dm_req); end
        vec_cnt++; if (head_s !== sb_q[0]) begin err_cnt++; $display("FAIL sb_head got %h want %h", head_s, sb_q[0]); end
        vec_cnt++; if (dm_be !== 4'b1000) begin err_cnt++; $display("FAIL sb_be got %b want 1000", dm_be); end
        dm_ack = 1'b1;
        clock_cycle();
        vec_cnt++; if (empty !== 1'b1 || dm_req !== 1'b0) begin err_cnt++; $display("FAIL sb_drain got empty=%b req=%b want 1/0", empty, dm_req); end
    endtask

    task automatic test_sh_misalign();
        set_store(2'b10, 32'h0000_2002, 32'h0000_1234, 1'b1);
        clock_cycle();
        vec_cnt++; if (head_s !== sb_q[0]) begin err_cnt++; $display("FAIL sh_head got %h want %h", head_s, sb_q[0]); end
        set_store(2'b10, 32'h0000_2001, 32'h0000_5678, 1'b0);
        #1;
        vec_cnt++; if (st_misalign !== 1'b1) begin err_cnt++; $display("FAIL sh_misalign got %b want 1", st_misalign); end
        clock_cycle();
        set_store(2'b11, 32'h0000_2006, 32'h0000_0000, 1'b0);
        st_valid = 1'b0;
        #1;
        vec_cnt++; if (st_misalign !== 1'b0) begin err_cnt++; $display("FAIL misalign_novalid got %b want 0", st_misalign); end
        st_valid = 1'b1;
        #1;
        vec_cnt++; if (st_misalign !== 1'b1) begin err_cnt++; $display("FAIL sw_misalign got %b want 1", st_misalign); end
        dm_ack = 1'b1;
        clock_cycle();
        vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL misalign_not_enq got empty=%b want 1", empty); end
    endtask

    task automatic test_full();
        set_store(2'b11, 32'h0000_3004, 32'hDEAD_BEEF, 1'b1);
        clock_cycle();
        set_store(2'b11, 32'h0000_3008, 32'hDEAD_BEEF, 1'b1);
        clock_cycle();
        vec_cnt++; if (st_ready !== 1'b0) begin err_cnt++; $display("FAIL full_ready got %b want 0", st_ready); end
        set_store(2'b11, 32'h0000_300C, 32'h1111_2222, 1'b0);
        dm_ack = 1'b1;
        clock_cycle();
        vec_cnt++; if (head_s !== sb_q[0]) begin err_cnt++; $display("FAIL full_refuse_head got %h want %h", head_s, sb_q[0]); end
        vec_cnt++; if (st_ready !== 1'b1) begin err_cnt++; $display("FAIL full_after_pop got %b want 1", st_ready); end
        set_store(2'b01, 32'h0000_3011, 32'hCAFE_F00D, 1'b1);
        dm_ack = 1'b1;
        clock_cycle();
        vec_cnt++; if (head_s !== sb_q[0]) begin err_cnt++; $display("FAIL pushpop_head got %h want %h", head_s, sb_q[0]); end
        vec_cnt++; if (empty !== 1'b0 || st_ready !== 1'b1) begin err_cnt++; $display("FAIL pushpop_count got empty=%b ready=%b want 0/1", empty, st_ready); end
        dm_ack = 1'b1;
        clock_cycle();
        vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL full_drain got %b want 1", empty); end
    endtask

    task automatic test_conflict();
        set_store(2'b11, 32'h0000_4000, 32'h0BAD_F00D, 1'b1);
        clock_cycle();
        set_store(2'b10, 32'h0000_5002, 32'h0000_ABCD, 1'b1);
        clock_cycle();
        ld_valid = 1'b1; ld_addr = 32'h0000_4002; #1;
        vec_cnt++; if (ld_conflict !== 1'b1) begin err_cnt++; $display("FAIL conf_same got %b want 1", ld_conflict); end
        ld_addr = 32'h0000_4004; #1;
        vec_cnt++; if (ld_conflict !== 1'b0) begin err_cnt++; $display("FAIL conf_next got %b want 0", ld_conflict); end
        ld_addr = 32'h0000_5000; #1;
        vec_cnt++; if (ld_conflict !== 1'b1) begin err_cnt++; $display("FAIL conf_tail got %b want 1", ld_conflict); end
        ld_valid = 1'b0; #1;
        vec_cnt++; if (ld_conflict !== 1'b0) begin err_cnt++; $display("FAIL conf_noload got %b want 0", ld_conflict); end
        ld_valid = 1'b1; ld_addr = 32'h0000_4001; dm_ack = 1'b1; #1;
        vec_cnt++; if (ld_conflict !== 1'b1) begin err_cnt++; $display("FAIL conf_ackcyc got %b want 1", ld_conflict); end
        clock_cycle();
        vec_cnt++; if (ld_conflict !== 1'b0) begin err_cnt++; $display("FAIL conf_retired got %b want 0", ld_conflict); end
        vec_cnt++; if (head_s !== sb_q[0]) begin err_cnt++; $display("FAIL conf_head got %h want %h", head_s, sb_q[0]); end
        ld_valid = 1'b0;
        dm_ack = 1'b1;
        clock_cycle();
    endtask

    task automatic test_reset_mid_drain();
        logic seen_req;
        set_store(2'b11, 32'h0000_6000, 32'h1234_5678, 1'b1);
        clock_cycle();
        set_store(2'b01, 32'h0000_6104, 32'h0000_0077, 1'b1);
        clock_cycle();
        vec_cnt++; if (dm_req !== 1'b1) begin err_cnt++; $display("FAIL mid_req got %b want 1", dm_req); end
        #2;
        reset = 1'b1;
        #1;
        vec_cnt++; if (dm_req !== 1'b0 || empty !== 1'b1) begin err_cnt++; $display("FAIL mid_rst got req=%b empty=%b want 0/1", dm_req, empty); end
        vec_cnt++; if (head_s !== '0) begin err_cnt++; $display("FAIL mid_rst_head got %h want 0", head_s); end
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            seen_req = seen_req | dm_req;
        end
        vec_cnt++; if (seen_req !== 1'b0) begin err_cnt++; $display("FAIL mid_no_write got %b want 0", seen_req); end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh_misalign();
        test_full();
        test_conflict();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
